// File: rtl/register_bank_sequencer.sv
// Single-word read/write sequencer for a bank of tri-state registers sharing D and Q buses.
// Optional write read-back verification is enabled by defining RDBACK_VERIFY_EN.
module register_bank_sequencer #(
  parameter int NrOfBits = 32,
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [AddrBits-1:0] req_addr,
  input  logic [NrOfBits-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NrOfBits-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic [NrOfBits-1:0] reg_d,
  output logic [NrOfRegs-1:0] reg_ce,
  output logic [NrOfRegs-1:0] reg_cs,
  input  logic [NrOfBits-1:0] bus_q
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_SEL, S_RD_CAP, S_RESP
`ifdef RDBACK_VERIFY_EN
    , S_VFY_SEL, S_VFY_CAP
`endif
  } state_t;

  localparam logic [AddrBits:0] NREGS = NrOfRegs[AddrBits:0];

  state_t                state_q, state_d;
  logic [AddrBits-1:0]   addr_q, addr_d;
  logic [NrOfBits-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [NrOfBits-1:0]   regd_q, regd_d;
  logic [NrOfRegs-1:0]   sel;
  logic                  addr_oor;

  assign addr_oor = ({1'b0, req_addr} >= NREGS);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      regd_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      regd_q  <= regd_d;
    end
  end

  // reg_d doubles as the latched write data, so read-back compares against it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    regd_d  = regd_q;
    if (Tick) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_d  = req_addr;
            rdata_d = '0;
            if (addr_oor) begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end else begin
              err_d = 1'b0;
              if (req_we) begin
                regd_d  = req_wdata;
                state_d = S_WR;
              end else begin
                state_d = S_RD_SEL;
              end
            end
          end
        end
`ifdef RDBACK_VERIFY_EN
        S_WR:      state_d = S_VFY_SEL;
        S_VFY_SEL: state_d = S_VFY_CAP;
        S_VFY_CAP: begin
          rdata_d = bus_q;
          err_d   = (bus_q != regd_q);
          state_d = S_RESP;
        end
`else
        S_WR:      state_d = S_RESP;
`endif
        S_RD_SEL:  state_d = S_RD_CAP;
        S_RD_CAP: begin
          rdata_d = bus_q;
          state_d = S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NrOfRegs; i++) sel[i] = (addr_q == i[AddrBits-1:0]);
  end

  // Strobes decode straight from the state register so Reset drops them at once.
  always_comb begin
    reg_ce = '0;
    reg_cs = '0;
    case (state_q)
      S_WR:                reg_ce = sel;
      S_RD_SEL, S_RD_CAP:  reg_cs = sel;
`ifdef RDBACK_VERIFY_EN
      S_VFY_SEL, S_VFY_CAP: reg_cs = sel;
`endif
      default: ;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign reg_d     = regd_q;

endmodule

// File: tb/tb_register_bank_sequencer.sv
// Directed bench for register_bank_sequencer with a small register-bank model on the Q bus.
module tb_register_bank_sequencer;
  logic        Clock = 1'b0;
  logic        Reset, Tick, req_valid, req_we, rsp_ready, req_valid6;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata, bus_q, bus_q6;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, reg_d;
  logic [7:0]  reg_ce, reg_cs;
  logic        req_ready6, rsp_valid6, rsp_err6;
  logic [31:0] rsp_rdata6, reg_d6;
  logic [5:0]  reg_ce6, reg_cs6;
  logic [31:0] mem [8];
  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  register_bank_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_d(reg_d), .reg_ce(reg_ce), .reg_cs(reg_cs), .bus_q(bus_q));

  register_bank_sequencer #(.NrOfRegs(6)) dut6 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .req_valid(req_valid6), .req_ready(req_ready6), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata6), .rsp_err(rsp_err6),
    .reg_d(reg_d6), .reg_ce(reg_ce6), .reg_cs(reg_cs6), .bus_q(bus_q6));

  assign bus_q6 = 32'h0;

  // Bank model: register 2 is stuck at zero, 4 and 5 hold preset values.
  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hCAFEF00D;
      mem[5] <= 32'h12345678;
    end else if (Tick) begin
      for (int i = 0; i < 8; i++)
        if (reg_ce[i] && i != 2) mem[i] <= reg_d;
    end
  end

  always_comb begin
    bus_q = 32'h0;
    for (int i = 0; i < 8; i++) if (reg_cs[i]) bus_q = mem[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Tick = 1'b1; req_valid = 1'b0; req_valid6 = 1'b0; req_we = 1'b0;
    req_addr = 3'd0; req_wdata = 32'h0; rsp_ready = 1'b0;
    step(); step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_reg_d", reg_d, 32'h0);
    chk("rst_ce_cs", {16'b0, reg_ce, reg_cs}, 32'h0);
    Reset = 1'b0;
    step();

    // Write addr 3
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 32'hDEADBEEF;
    step();
    req_valid = 1'b0;
    chk("wr_ce", {24'b0, reg_ce}, 32'h08);
    chk("wr_d", reg_d, 32'hDEADBEEF);
    chk("wr_cs", {24'b0, reg_cs}, 32'h0);
    chk("wr_req_ready", {31'b0, req_ready}, 32'h0);
    chk("wr_rsp_valid_early", {31'b0, rsp_valid}, 32'h0);
    step();
    chk("wr_ce_one_cycle", {24'b0, reg_ce}, 32'h0);
`ifdef RDBACK_VERIFY_EN
    chk("wr_vfy_sel_cs", {24'b0, reg_cs}, 32'h08);
    step();
    chk("wr_vfy_cap_cs", {24'b0, reg_cs}, 32'h08);
    step();
    chk("wr_rdata", rsp_rdata, 32'hDEADBEEF);
`else
    chk("wr_rdata", rsp_rdata, 32'h0);
`endif
    chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("wr_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("wr_resp_cs", {24'b0, reg_cs}, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_done_valid", {31'b0, rsp_valid}, 32'h0);
    chk("wr_done_ready", {31'b0, req_ready}, 32'h1);
    chk("wr_reg_d_held", reg_d, 32'hDEADBEEF);

    // Read addr 5
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd5;
    step();
    req_valid = 1'b0;
    chk("rd_sel_cs", {24'b0, reg_cs}, 32'h20);
    chk("rd_sel_ce", {24'b0, reg_ce}, 32'h0);
    step();
    chk("rd_cap_cs", {24'b0, reg_cs}, 32'h20);
    chk("rd_cap_valid", {31'b0, rsp_valid}, 32'h0);
    step();
    chk("rd_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("rd_rdata", rsp_rdata, 32'h12345678);
    chk("rd_resp_cs", {24'b0, reg_cs}, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Out-of-range read on the 6-register instance
    req_valid6 = 1'b1; req_we = 1'b0; req_addr = 3'd7;
    chk("oor_accept_cs_ce", {20'b0, reg_cs6, reg_ce6}, 32'h0);
    step();
    req_valid6 = 1'b0;
    chk("oor_rsp_valid", {31'b0, rsp_valid6}, 32'h1);
    chk("oor_rsp_err", {31'b0, rsp_err6}, 32'h1);
    chk("oor_rdata", rsp_rdata6, 32'h0);
    chk("oor_cs_ce", {20'b0, reg_cs6, reg_ce6}, 32'h0);
    chk("oor_req_ready", {31'b0, req_ready6}, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("oor_done", {30'b0, rsp_valid6, req_ready6}, 32'h1);

    // Tick gating and backpressure, read addr 4
    req_valid = 1'b1; req_addr = 3'd4;
    step();
    req_valid = 1'b0;
    chk("tk_sel_cs", {24'b0, reg_cs}, 32'h10);
    Tick = 1'b0;
    step();
    chk("tk_hold_sel_cs", {24'b0, reg_cs}, 32'h10);
    chk("tk_hold_sel_valid", {31'b0, rsp_valid}, 32'h0);
    Tick = 1'b1;
    step();
    chk("tk_cap_cs", {24'b0, reg_cs}, 32'h10);
    Tick = 1'b0;
    step();
    chk("tk_hold_cap_valid", {31'b0, rsp_valid}, 32'h0);
    chk("tk_hold_cap_cs", {24'b0, reg_cs}, 32'h10);
    Tick = 1'b1;
    step();
    chk("tk_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("tk_rdata", rsp_rdata, 32'hCAFEF00D);
    req_valid = 1'b1; req_addr = 3'd5;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1; Tick = 1'b0;
    step();
    chk("bp_tick0_hold", {31'b0, rsp_valid}, 32'h1);
    Tick = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'h0);
    chk("bp_release_ready", {31'b0, req_ready}, 32'h1);

    // Reset mid-read while in RD_CAP
    req_valid = 1'b1; req_addr = 3'd5;
    step();
    req_valid = 1'b0;
    step();
    chk("mr_cap_cs", {24'b0, reg_cs}, 32'h20);
    #2 Reset = 1'b1;
    #1;
    chk("mr_async_cs", {24'b0, reg_cs}, 32'h0);
    chk("mr_async_ready", {31'b0, req_ready}, 32'h1);
    @(posedge Clock);
    #1 Reset = 1'b0;
    step();
    chk("mr_no_rsp", {31'b0, rsp_valid}, 32'h0);
    chk("mr_ready", {31'b0, req_ready}, 32'h1);
    chk("mr_rdata", rsp_rdata, 32'h0);
    chk("mr_reg_d", reg_d, 32'h0);
    step();
    chk("mr_no_rsp_late", {31'b0, rsp_valid}, 32'h0);

    // Write to the stuck-at-zero register 2
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_wdata = 32'hA5A5A5A5;
    step();
    req_valid = 1'b0;
    chk("w2_ce", {24'b0, reg_ce}, 32'h04);
    chk("w2_d", reg_d, 32'hA5A5A5A5);
    step();
`ifdef RDBACK_VERIFY_EN
    chk("w2_vfy_cs", {24'b0, reg_cs}, 32'h04);
    step();
    step();
    chk("w2_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("w2_rsp_err", {31'b0, rsp_err}, 32'h1);
`else
    chk("w2_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("w2_rsp_err", {31'b0, rsp_err}, 32'h0);
`endif
    chk("w2_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w2_done", {31'b0, req_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
